// File: rtl/cache_fill_ctrl_if.sv
// Fill-engine bus: requester miss lines, memory read port and cache fill port.
// master = fill engine, slave = caches plus memory.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]        miss_req;
  logic [NUM_REQ*ADDR_W-1:0] miss_addr;
  logic                      mem_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_data_valid;
  logic [DATA_W-1:0]         mem_data_in;
  logic                      fill_we;
  logic [ADDR_W-1:0]         fill_addr;
  logic [DATA_W-1:0]         fill_data;
  logic [NUM_REQ-1:0]        fill_sel;
  logic                      tag_we;
  logic [NUM_REQ-1:0]        fill_done;
  logic                      busy;
  logic [NUM_REQ-1:0]        stall;

  modport master (
    input  miss_req, miss_addr, mem_data_valid, mem_data_in,
    output mem_en, mem_addr, fill_we, fill_addr, fill_data,
    output fill_sel, tag_we, fill_done, busy, stall
  );

  modport slave (
    output miss_req, miss_addr, mem_data_valid, mem_data_in,
    input  mem_en, mem_addr, fill_we, fill_addr, fill_data,
    input  fill_sel, tag_we, fill_done, busy, stall
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Round-robin multi-requester cache miss fill engine for a pipelined memory.
// Optional CRITICAL_WORD_FIRST_EN: fetch the missed word first, wrap in block.
module cache_fill_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4,
  parameter int NUM_REQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  cache_fill_ctrl_if.master bus
);
  localparam int OW = $clog2(WORDS);
  localparam int CW = OW + 1;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
  localparam logic [CW-1:0] FULL = CW'(WORDS);
  localparam logic [ADDR_W-1:0] BMASK = ~ADDR_W'(2 * WORDS - 1);

  if (WORDS < 2 || NUM_REQ < 1 || MEM_LAT < 1 || ADDR_W <= OW + 1)
  begin : g_bad_cfg
    $error("cache_fill_ctrl: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      rr_q, rr_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [OW-1:0]      start_q, start_d;
  logic [CW-1:0]      issue_q, issue_d;
  logic [CW-1:0]      recv_q, recv_d;
  logic [GW-1:0]      gnt_idx;
  logic               gnt_ok;
  logic [ADDR_W-1:0]  req_addr;
  logic [OW-1:0]      iss_ord, rcv_ord;
  logic [NUM_REQ-1:0] grant_oh;

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_ok && bus.miss_req[(int'(rr_q) + i) % NUM_REQ]) begin
        gnt_ok  = 1'b1;
        gnt_idx = GW'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  assign req_addr = bus.miss_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  // OW-bit sums wrap within the block, so no carry into the base.
  assign iss_ord  = issue_q[OW-1:0] + start_q;
  assign rcv_ord  = recv_q[OW-1:0] + start_q;
  assign grant_oh = NUM_REQ'(1) << grant_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    base_d   = base_q;
    start_d  = start_q;
    issue_d  = issue_q;
    recv_d   = recv_q;
    bus.mem_en    = 1'b0;
    bus.mem_addr  = '0;
    bus.fill_we   = 1'b0;
    bus.fill_addr = '0;
    bus.fill_data = '0;
    bus.tag_we    = 1'b0;
    bus.fill_done = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_ok) begin
          grant_d = gnt_idx;
          base_d  = req_addr & BMASK;
`ifdef CRITICAL_WORD_FIRST_EN
          start_d = req_addr[OW:1];
`else
          start_d = '0;
`endif
          issue_d = '0;
          recv_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (issue_q < FULL) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = base_q | ADDR_W'({iss_ord, 1'b0});
          issue_d      = issue_q + 1'b1;
        end
        if (bus.mem_data_valid && recv_q < FULL) begin
          bus.fill_we   = 1'b1;
          bus.fill_addr = base_q | ADDR_W'({rcv_ord, 1'b0});
          bus.fill_data = bus.mem_data_in;
          recv_d        = recv_q + 1'b1;
          if (recv_q == LAST) begin
            bus.tag_we = 1'b1;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        bus.fill_done = grant_oh;
        rr_d    = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.fill_sel = bus.busy ? grant_oh : '0;
  // Gated by rst so every output is quiet while reset is held.
  assign bus.stall    = rst ? '0 : (bus.miss_req & ~bus.fill_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      base_q  <= '0;
      start_q <= '0;
      issue_q <= '0;
      recv_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      base_q  <= base_d;
      start_q <= start_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
    end
  end
endmodule
